// File: rtl/branch_predictor_pkg.sv
// Shared core types for the fetch-side branch path: direction encoding and
// the 2-bit saturating counter encoding used by the predictor tables.
package branch_predictor_pkg;

    typedef enum logic {
        BR_NOT_TAKEN = 1'b0,
        BR_TAKEN     = 1'b1
    } br_dir_e;

    typedef logic [1:0] sat_cnt_t;

    localparam sat_cnt_t CNT_STRONG_NT = 2'b00;
    localparam sat_cnt_t CNT_WEAK_NT   = 2'b01;
    localparam sat_cnt_t CNT_WEAK_T    = 2'b10;
    localparam sat_cnt_t CNT_STRONG_T  = 2'b11;

    function automatic logic cnt_predicts_taken(input sat_cnt_t cnt);
        return (cnt >= CNT_WEAK_T);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for one 2-bit saturating counter: count up on taken,
// down on not-taken, sticking at the strong ends.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  sat_cnt_t cnt,
    input  logic     inc,
    output sat_cnt_t nxt
);

    always_comb begin
        nxt = cnt;
        if (inc) begin
            if (cnt != CNT_STRONG_T) nxt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_STRONG_NT) nxt = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped bimodal predictor with a tagged BTB; one-cycle registered
// lookup, resolved-branch updates written on the same clock.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int WordSize  = 32,
    parameter int IndexBits = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WordSize-1:0] fetch_pc,
    input  logic                stall,
    input  logic                upd_valid,
    input  logic [WordSize-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [WordSize-1:0] upd_target,
    output logic                pred_taken,
    output logic [WordSize-1:0] pred_pc,
    output logic [WordSize-1:0] pred_addr
);

    localparam int Depth   = 2 ** IndexBits;
    localparam int TagBits = WordSize - IndexBits - 2;

    sat_cnt_t            cnt_q   [Depth];
    logic                valid_q [Depth];
    logic [TagBits-1:0]  tag_q   [Depth];
    logic [WordSize-1:0] tgt_q   [Depth];

    logic [IndexBits-1:0] fetch_idx;
    logic [IndexBits-1:0] upd_idx;
    logic [TagBits-1:0]   fetch_tag;
    logic [TagBits-1:0]   upd_tag;
    logic                 unused_upd_low;

    assign fetch_idx      = fetch_pc[IndexBits+1:2];
    assign fetch_tag      = fetch_pc[WordSize-1:IndexBits+2];
    assign upd_idx        = upd_pc[IndexBits+1:2];
    assign upd_tag        = upd_pc[WordSize-1:IndexBits+2];
    assign unused_upd_low = ^upd_pc[1:0];

    // Lookup reads the tables before this edge's update lands, so a same-index
    // update in the same cycle is seen only by the following lookup.
    logic                btb_hit;
    logic                lookup_taken;
    logic [WordSize-1:0] lookup_addr;

    assign btb_hit      = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign lookup_taken = btb_hit && cnt_predicts_taken(cnt_q[fetch_idx]);
    assign lookup_addr  = lookup_taken ? tgt_q[fetch_idx] : fetch_pc + WordSize'(4);

    sat_cnt_t cnt_upd;

    sat_counter2 u_sat_counter2 (
        .cnt (cnt_q[upd_idx]),
        .inc (upd_taken),
        .nxt (cnt_upd)
    );

    // upd_valid qualifies upd_pc/upd_taken/upd_target for exactly one cycle;
    // there is no ready: every update is accepted, stalled or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                cnt_q[i]   <= CNT_WEAK_NT;
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            cnt_q[upd_idx] <= cnt_upd;
            if (upd_taken) valid_q[upd_idx] <= 1'b1;
        end
    end

    // Tag/target need no reset: a cleared valid bit hides whatever they hold.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_taken <= 1'b0;
            pred_pc    <= '0;
            pred_addr  <= '0;
        end else if (!stall) begin
            pred_taken <= lookup_taken;
            pred_pc    <= fetch_pc;
            pred_addr  <= lookup_addr;
        end
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter WordSize, default 32, SHALL set the width of PC and target addresses.
REQ-002 Parameter IndexBits, default 6, SHALL set the table depth to 2**IndexBits entries.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 fetch_pc  input  WordSize  SHALL be the PC looked up this cycle.
REQ-006 stall  input  1  SHALL hold all prediction outputs when high.
REQ-007 upd_valid  input  1  SHALL qualify a resolved-branch update this cycle.
REQ-008 upd_pc  input  WordSize  SHALL be the PC of the resolved branch.
REQ-009 upd_taken  input  1  SHALL be the actual branch outcome.
REQ-010 upd_target  input  WordSize  SHALL be the actual taken target.
REQ-011 pred_taken  output  1  SHALL be the registered taken prediction, feeding the branch manager.
REQ-012 pred_pc  output  WordSize  SHALL be the registered PC the prediction belongs to.
REQ-013 pred_addr  output  WordSize  SHALL be the registered predicted next address.

Function
REQ-014 Index SHALL be pc[IndexBits+1:2]; tag SHALL be pc[WordSize-1:IndexBits+2].
REQ-015 Each entry SHALL hold a 2-bit saturating counter, a BTB valid bit, a tag and a WordSize target.
REQ-016 Lookup latency SHALL be one cycle: outputs at edge N+1 reflect fetch_pc sampled at edge N.
REQ-017 BTB hit SHALL mean valid set and stored tag equal to the fetch_pc tag.
REQ-018 pred_taken SHALL be 1 only when counter >= 2 and BTB hit.
REQ-019 pred_addr SHALL be the BTB target when pred_taken is 1, otherwise fetch_pc + 4, modulo 2**WordSize (wrap, no carry out).
REQ-020 pred_pc SHALL equal the sampled fetch_pc.
REQ-021 When upd_valid is 1, the counter at upd_pc's index SHALL increment if upd_taken, else decrement, saturating at 3 and 0.
REQ-022 When upd_valid and upd_taken are 1, the BTB entry SHALL be written: valid=1, tag from upd_pc, target=upd_target.
REQ-023 A not-taken update SHALL leave the BTB fields unchanged.
REQ-024 A lookup and an update to the same index in the same cycle SHALL predict from pre-update state; the update SHALL be visible to the next lookup.
REQ-025 Updates SHALL apply regardless of stall.
REQ-026 When stall is 1, all three outputs SHALL hold their previous values.
REQ-027 With upd_valid 0, table state SHALL not change.

Reset
REQ-028 On rst assertion, without waiting for clk, all counters SHALL become 01 (weakly not-taken) and all BTB valid bits SHALL clear.
REQ-029 On rst assertion, pred_taken, pred_pc and pred_addr SHALL become 0.
REQ-030 Reset mid-update SHALL discard the update; the first lookup after deassertion SHALL see reset state.

Structure
REQ-031 The counter encoding and the weakly-not-taken constant SHALL live in the shared core package, alongside the existing branch-path types.
REQ-032 The 2-bit saturating counter update SHALL be a sub-module named sat_counter2; the tables and the output register stage SHALL stay in branch_predictor.

Verification
REQ-033 Reset, then fetch_pc=0x100 -> next cycle: pred_taken=0, pred_pc=0x100, pred_addr=0x104.
REQ-034 One update (pc=0x100, taken, target=0x200), then lookup 0x100 -> pred_taken=1, pred_addr=0x200.
REQ-035 Four taken updates to 0x100, then one not-taken -> still taken; one more not-taken (counter 1) -> pred_taken=0, pred_addr=0x104.
REQ-036 Train 0x100 taken, then lookup 0x200 (same index, different tag) -> pred_taken=0, pred_addr=0x204; lookup 0xFFFFFFFC with a BTB miss -> pred_addr=0x0.
REQ-037 Lookup and taken update to 0x100 in the same cycle from reset state -> that prediction is not-taken; the next lookup of 0x100 is taken.
REQ-038 Stall high for 3 cycles while fetch_pc changes -> outputs constant; assert rst mid-stall -> outputs 0 immediately, and the trained 0x100 predicts not-taken after release.
